cursor_overlay: RTL and testbench
=================================

# cursor_overlay

Pixel-clock stage directly downstream of the frame-buffer VGA controller. Consumes its video stream (HS, VS, BLANK, RGB) and inserts a 16×16 monochrome hardware cursor at a programmable screen position. Drives the LCD-facing `video_if`. All timing signals are delayed to stay aligned with the modified RGB.

## Interface
- `HDISP`, 800, visible pixels per line.
- `VDISP`, 480, visible lines per frame.
- `pixel_clk  in  1`: pixel clock. All logic is in this domain.
- `pixel_rst  in  1`: asynchronous, active-high reset.
- `video_ifs  video_if.slave  —`: input stream from the VGA controller. `BLANK` high marks a visible pixel.
- `video_ifm  video_if.master  —`: output stream. `video_ifm.CLK = pixel_clk`.
- `cursor_en  in  1`: cursor visible.
- `cursor_mode  in  1`:
  - 0: set pixels take `cursor_color`.
  - 1: set pixels take input RGB XOR 24'hFFFFFF.
- `cursor_x  in  $clog2(HDISP)`: left column of the cursor.
- `cursor_y  in  $clog2(VDISP)`: top line of the cursor.
- `cursor_color  in  24`: solid colour used in mode 0.
- `bm_we  in  1`: bitmap row write strobe.
- `bm_addr  in  4`: bitmap row index.
- `bm_data  in  16`: bitmap row data. Bit 15 is the leftmost pixel.

## Operation
- **Coordinate tracking** (from the input stream):
  - `x` increments on every cycle with `BLANK`=1 and clears on every cycle with `BLANK`=0.
  - `y` increments on each `BLANK` 1→0 transition (end of visible line).
  - `y` clears while `VS`=0.
  - Counters saturate at `HDISP-1` / `VDISP-1` and never wrap.
- **Shadow registers:** `cursor_en/mode/x/y/color` are captured into shadow registers on every cycle with input `VS`=0. Position and enable therefore change only between frames, and a mid-frame change never tears the cursor.
- **Bitmap:** 16×16-bit register array.
  - `bm_we` writes row `bm_addr` at the clock edge and takes effect immediately (no shadowing).
  - A write and a read of the same row in the same cycle: the read returns the old row.
- **Hit test:**
  - `dx = x - sx`, `dy = y - sy`, computed one bit wider than the operands.
  - Hit when `BLANK`=1, shadow enable is set, and `0 ≤ dx ≤ 15` and `0 ≤ dy ≤ 15`. Negative results (MSB set) are misses.
  - Parts of the cursor beyond `HDISP`/`VDISP` are clipped naturally. No wrap to column/line 0.
- **Pipeline stage 1 (registered):** hit flag, `dx[3:0]`, bitmap row `dy[3:0]`, input RGB, shadow mode/colour, and HS/VS/BLANK.
- **Pipeline stage 2 (registered):**
  - Pixel set = `hit & row[15-dx]`.
  - Output RGB is the mode-selected value if set, otherwise the stage-1 RGB.
  - HS/VS/BLANK pass through unchanged.
- Pixels outside `BLANK`=1 are never modified.

## Timing
- Latency is 2 pixel_clk cycles for RGB, HS, VS and BLANK alike. Relative alignment of all four is exactly preserved.
- Throughput: 1 pixel/cycle, no stalls, no backpressure.
- Reset values:
  - `video_ifm.HS`=1, `VS`=1, `BLANK`=0, `RGB`=0.
  - Both pipeline stages cleared.
  - `x`=0, `y`=0.
  - Shadow `cursor_en`=0, all other shadows 0.
  - Bitmap all zeros.
- Reset released mid-frame: the cursor stays hidden until the first `VS` low. Because `y` is unknown until then, the stage forces a miss until the first VS has been seen (`frame_valid` flag, reset 0).
- `cursor_x` = `HDISP-1`: only column 0 of the bitmap is visible.

## Structure
- Shared package `video_overlay_pkg`:
  - `CURSOR_SIZE`=16
  - `typedef logic [23:0] rgb_t`
  - `typedef logic [15:0] cursor_row_t`
  - `typedef enum logic {CUR_SOLID, CUR_INVERT} cursor_mode_t`
- One sub-module, `cursor_bitmap`: 16-row register array with write port and registered read. It is reused by later overlays.
- Coordinate tracking, shadowing, hit test and the output mux stay in `cursor_overlay`.

## Test plan
- **Pass-through:** `cursor_en`=0 with a mire stream → output equals input delayed by exactly 2 cycles on all four signals.
- **Solid cursor:**
  - Setup: bitmap rows all 16'hFFFF, `cursor_x`=100, `cursor_y`=50, colour 24'hFF0000, mode 0.
  - Expected: pixels (100..115, 50..65) read FF0000 and (99,50)/(116,50)/(100,49)/(100,66) are unchanged.
- **Invert mode:** row 0 = 16'h8001, input RGB 24'h123456 → (cx,cy) and (cx+15,cy) read EDCBA9, (cx+1,cy) reads 123456.
- **Edge clipping:** `cursor_x`=795, `cursor_y`=475 → only 5×5 pixels modified, and column 0 of the next line is untouched.
- **Frame coherence:** change `cursor_x` from 100 to 200 mid-frame → the current frame still draws at 100, and the next frame draws at 200.
- **Reset mid-frame:** assert `pixel_rst` during visible line 200 → outputs HS=1/VS=1/BLANK=0/RGB=0 immediately. After release, no cursor pixels appear until after the next VS low.

Source files
------------

// File: rtl/video_overlay_pkg.sv
// Shared types and display geometry for the pixel-clock overlay stages.
package video_overlay_pkg;

    localparam int HDISP       = 800;
    localparam int VDISP       = 480;
    localparam int CURSOR_SIZE = 16;

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int CW = $clog2(CURSOR_SIZE);

    typedef logic [23:0]            rgb_t;
    typedef logic [CURSOR_SIZE-1:0] cursor_row_t;
    typedef enum logic {CUR_SOLID, CUR_INVERT} cursor_mode_t;

    localparam rgb_t RGB_INVERT_MASK = 24'hFF_FFFF;

endpackage

// File: rtl/video_if.sv
// Parallel video stream: sync, active-video flag and 24-bit RGB.
interface video_if;
    import video_overlay_pkg::*;

    logic CLK;
    logic HS;
    logic VS;
    logic BLANK;
    rgb_t RGB;

    // The consumer runs on its own pixel clock, so CLK is not part of its view.
    modport master (output CLK, HS, VS, BLANK, RGB);
    modport slave  (input  HS, VS, BLANK, RGB);

endinterface

// File: rtl/cursor_bitmap.sv
// 16-row cursor bitmap: one write port, one registered read port.
module cursor_bitmap
    import video_overlay_pkg::*;
(
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          i_we,
    input  logic [CW-1:0] i_waddr,
    input  cursor_row_t   i_wdata,
    input  logic [CW-1:0] i_raddr,
    output cursor_row_t   o_rdata
);

    cursor_row_t r_rows [CURSOR_SIZE];
    cursor_row_t r_rdata;

    // NOTE: the array is small flops, not RAM, so it takes the async reset;
    // a same-row write and read in one cycle returns the old row.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            for (int i = 0; i < CURSOR_SIZE; i++) begin
                r_rows[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_rows[i_waddr] <= i_wdata;
            end
            r_rdata <= r_rows[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cursor_overlay.sv
// Inserts a 16x16 monochrome hardware cursor into a video stream with a
// fixed two-cycle latency on RGB and all timing signals.
module cursor_overlay
    import video_overlay_pkg::*;
(
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    video_if.slave        video_ifs,
    video_if.master       video_ifm,
    input  logic          cursor_en,
    input  logic          cursor_mode,
    input  logic [XW-1:0] cursor_x,
    input  logic [YW-1:0] cursor_y,
    input  rgb_t          cursor_color,
    input  logic          bm_we,
    input  logic [CW-1:0] bm_addr,
    input  cursor_row_t   bm_data
);

    localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_blank_d;

    logic          r_frame_valid;
    logic          r_sh_en;
    cursor_mode_t  r_sh_mode;
    logic [XW-1:0] r_sh_x;
    logic [YW-1:0] r_sh_y;
    rgb_t          r_sh_color;

    logic [XW:0]   w_dx;
    logic [YW:0]   w_dy;
    logic          w_hit;
    cursor_row_t   w_s1_row;

    logic          r_s1_hit;
    logic [CW-1:0] r_s1_dx;
    rgb_t          r_s1_rgb;
    cursor_mode_t  r_s1_mode;
    rgb_t          r_s1_color;
    logic          r_s1_hs;
    logic          r_s1_vs;
    logic          r_s1_blank;

    logic          w_pix_set;
    rgb_t          w_rgb_next;

    logic          r_o_hs;
    logic          r_o_vs;
    logic          r_o_blank;
    rgb_t          r_o_rgb;

    // x counts visible pixels in the line, y counts completed visible lines.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_blank_d <= 1'b0;
        end else begin
            r_blank_d <= video_ifs.BLANK;
            if (!video_ifs.BLANK) begin
                r_x <= '0;
            end else if (r_x != X_MAX) begin
                r_x <= r_x + XW'(1);
            end
            if (!video_ifs.VS) begin
                r_y <= '0;
            end else if (r_blank_d && !video_ifs.BLANK && r_y != Y_MAX) begin
                r_y <= r_y + YW'(1);
            end
        end
    end

    // Cursor controls only move during vertical sync, so a frame never tears.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_frame_valid <= 1'b0;
            r_sh_en       <= 1'b0;
            r_sh_mode     <= CUR_SOLID;
            r_sh_x        <= '0;
            r_sh_y        <= '0;
            r_sh_color    <= '0;
        end else if (!video_ifs.VS) begin
            r_frame_valid <= 1'b1;
            r_sh_en       <= cursor_en;
            r_sh_mode     <= cursor_mode_t'(cursor_mode);
            r_sh_x        <= cursor_x;
            r_sh_y        <= cursor_y;
            r_sh_color    <= cursor_color;
        end
    end

    // One extra bit turns "left of / above the cursor" into a set MSB.
    assign w_dx  = {1'b0, r_x} - {1'b0, r_sh_x};
    assign w_dy  = {1'b0, r_y} - {1'b0, r_sh_y};
    assign w_hit = video_ifs.BLANK && r_sh_en && r_frame_valid
                   && (w_dx[XW:CW] == '0) && (w_dy[YW:CW] == '0);

    cursor_bitmap u_bitmap (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .i_we      (bm_we),
        .i_waddr   (bm_addr),
        .i_wdata   (bm_data),
        .i_raddr   (w_dy[CW-1:0]),
        .o_rdata   (w_s1_row)
    );

    // Stage-1 syncs reset to the idle level so no false pulse follows reset.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_s1_hit   <= 1'b0;
            r_s1_dx    <= '0;
            r_s1_rgb   <= '0;
            r_s1_mode  <= CUR_SOLID;
            r_s1_color <= '0;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
            r_s1_blank <= 1'b0;
        end else begin
            r_s1_hit   <= w_hit;
            r_s1_dx    <= w_dx[CW-1:0];
            r_s1_rgb   <= video_ifs.RGB;
            r_s1_mode  <= r_sh_mode;
            r_s1_color <= r_sh_color;
            r_s1_hs    <= video_ifs.HS;
            r_s1_vs    <= video_ifs.VS;
            r_s1_blank <= video_ifs.BLANK;
        end
    end

    // Bit 15 of a row is the leftmost cursor column.
    assign w_pix_set = r_s1_hit & w_s1_row[CW'(CURSOR_SIZE - 1) - r_s1_dx];

    // NOTE: default first so every path assigns w_rgb_next and no latch forms.
    always_comb begin
        w_rgb_next = r_s1_rgb;
        if (w_pix_set) begin
            case (r_s1_mode)
                CUR_SOLID:  w_rgb_next = r_s1_color;
                CUR_INVERT: w_rgb_next = r_s1_rgb ^ RGB_INVERT_MASK;
                default:    w_rgb_next = r_s1_rgb;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_o_hs    <= 1'b1;
            r_o_vs    <= 1'b1;
            r_o_blank <= 1'b0;
            r_o_rgb   <= '0;
        end else begin
            r_o_hs    <= r_s1_hs;
            r_o_vs    <= r_s1_vs;
            r_o_blank <= r_s1_blank;
            r_o_rgb   <= w_rgb_next;
        end
    end

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.HS    = r_o_hs;
    assign video_ifm.VS    = r_o_vs;
    assign video_ifm.BLANK = r_o_blank;
    assign video_ifm.RGB   = r_o_rgb;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed frames through cursor_overlay, checked every cycle against a
// screen-coordinate model of the cursor plus hand-computed pixel values.
`timescale 1ns/1ps
module tb_cursor_overlay;
    import video_overlay_pkg::*;

    localparam rgb_t BLANK_RGB = 24'h0F0F0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          pixel_rst;
    logic          cursor_en;
    logic          cursor_mode;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    rgb_t          cursor_color;
    logic          bm_we;
    logic [CW-1:0] bm_addr;
    cursor_row_t   bm_data;

    video_if vin ();
    video_if vout ();
    assign vin.CLK = clk;

    cursor_overlay dut (
        .pixel_clk    (clk),
        .pixel_rst    (pixel_rst),
        .video_ifs    (vin),
        .video_ifm    (vout),
        .cursor_en    (cursor_en),
        .cursor_mode  (cursor_mode),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .cursor_color (cursor_color),
        .bm_we        (bm_we),
        .bm_addr      (bm_addr),
        .bm_data      (bm_data)
    );

    typedef struct {
        logic hs;
        logic vs;
        logic blank;
        rgb_t rgb;
        rgb_t rgb_in;
        int   col;
        int   line;
    } exp_t;

    typedef struct {
        logic [CW-1:0] a;
        cursor_row_t   d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    exp_t        ce;
    rgb_t        cap [int];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_mod = 0;
    bit          cmp_en = 1'b0;
    bit          const_rgb = 1'b0;

    // Model of what the screen should show: frame-latched controls + bitmap.
    cursor_row_t m_bm [CURSOR_SIZE];
    bit          m_fv;
    bit          m_en;
    bit          m_mode;
    int          m_x;
    int          m_y;
    rgb_t        m_color;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic rgb_t pat(input int col, input int line);
        if (const_rgb) return 24'h123456;
        return {col[7:0], line[7:0], 8'(col * 3 + line)};
    endfunction

    function automatic int key(input int col, input int line);
        return line * 1024 + col;
    endfunction

    function automatic rgb_t model_rgb(input logic blank, input rgb_t in, input int col, input int line);
        int dx;
        int dy;
        dx = col - m_x;
        dy = line - m_y;
        if (!blank || !m_fv || !m_en) return in;
        if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return in;
        if (!m_bm[dy][15 - dx]) return in;
        return m_mode ? (in ^ 24'hFFFFFF) : m_color;
    endfunction

    task automatic model_reset();
        m_fv = 0; m_en = 0; m_mode = 0; m_x = 0; m_y = 0; m_color = '0;
        for (int i = 0; i < CURSOR_SIZE; i++) m_bm[i] = '0;
    endtask

    task automatic load_bitmap(input cursor_row_t row0, input cursor_row_t rest);
        for (int i = 0; i < CURSOR_SIZE; i++) begin
            wr_t w;
            w.a = CW'(i);
            w.d = (i == 0) ? row0 : rest;
            wr_q.push_back(w);
        end
    endtask

    // Drive one pixel slot, record its expected output, wait for the edge.
    task automatic cycle(input logic hs, input logic vs, input logic blank,
                         input rgb_t rgb, input int col, input int line);
        exp_t e;
        wr_t  w;
        vin.HS = hs; vin.VS = vs; vin.BLANK = blank; vin.RGB = rgb;
        bm_we = 1'b0;
        if (!blank && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            bm_we = 1'b1; bm_addr = w.a; bm_data = w.d;
        end
        e.hs = hs; e.vs = vs; e.blank = blank; e.rgb_in = rgb;
        e.col = col; e.line = line;
        e.rgb = model_rgb(blank, rgb, col, line);
        exp_q.push_back(e);
        if (bm_we) m_bm[bm_addr] = bm_data;
        if (!vs) begin
            m_fv = 1; m_en = cursor_en; m_mode = cursor_mode;
            m_x = cursor_x; m_y = cursor_y; m_color = cursor_color;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, BLANK_RGB, -1, -1);
    endtask

    task automatic do_reset();
        #2 pixel_rst = 1'b1;
        #1;
        check("rst_mid_hs",    32'(vout.HS),    32'd1);
        check("rst_mid_vs",    32'(vout.VS),    32'd1);
        check("rst_mid_blank", 32'(vout.BLANK), 32'd0);
        check("rst_mid_rgb",   32'(vout.RGB),   32'd0);
        cmp_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 pixel_rst = 1'b0;
        exp_q.delete();
        cmp_en = 1'b1;
        load_bitmap(16'hFFFF, 16'hFFFF);
    endtask

    task automatic frame(input int nlines, input int w, input int long_from,
                         input int rst_line, input int chg_line, input int chg_x);
        int width;
        n_mod = 0;
        cap.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, BLANK_RGB, -1, -1);
        for (int ln = 0; ln < nlines; ln++) begin
            width = (ln >= long_from) ? HDISP : w;
            if (ln == chg_line) cursor_x = XW'(chg_x);
            cycle(1'b1, 1'b1, 1'b0, BLANK_RGB, -1, -1);
            cycle(1'b0, 1'b1, 1'b0, BLANK_RGB, -1, -1);
            cycle(1'b0, 1'b1, 1'b0, BLANK_RGB, -1, -1);
            cycle(1'b1, 1'b1, 1'b0, BLANK_RGB, -1, -1);
            for (int c = 0; c < width; c++) begin
                cycle(1'b1, 1'b1, 1'b1, pat(c, ln), c, ln);
                if (ln == rst_line && c == 10) do_reset();
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, BLANK_RGB, -1, -1);
    endtask

    // Output for the pixel driven two slots ago is stable at this edge.
    always @(negedge clk) begin
        if (cmp_en && exp_q.size() >= 3) begin
            ce = exp_q.pop_front();
            check($sformatf("pix(%0d,%0d)", ce.col, ce.line),
                  32'({vout.HS, vout.VS, vout.BLANK, vout.RGB}),
                  32'({ce.hs, ce.vs, ce.blank, ce.rgb}));
            if (ce.blank) begin
                cap[key(ce.col, ce.line)] = vout.RGB;
                if (vout.RGB !== ce.rgb_in) n_mod++;
            end
        end
    end

    initial begin
        pixel_rst = 1'b1;
        vin.HS = 1'b1; vin.VS = 1'b1; vin.BLANK = 1'b0; vin.RGB = 24'hABCDEF;
        bm_we = 1'b0; bm_addr = '0; bm_data = '0;
        cursor_en = 1'b0; cursor_mode = 1'b0; cursor_x = '0; cursor_y = '0;
        cursor_color = '0;
        model_reset();
        #3;
        check("rst_hs",    32'(vout.HS),    32'd1);
        check("rst_vs",    32'(vout.VS),    32'd1);
        check("rst_blank", 32'(vout.BLANK), 32'd0);
        check("rst_rgb",   32'(vout.RGB),   32'd0);
        @(posedge clk);
        #1 pixel_rst = 1'b0;
        exp_q.delete();
        cmp_en = 1'b1;

        // Pass-through with the cursor disabled.
        load_bitmap(16'hFFFF, 16'hFFFF);
        idle(20);
        cursor_x = 10'd100; cursor_y = 9'd50; cursor_color = 24'hFF0000;
        frame(20, 40, 9999, -1, -1, 0);
        check("pt_modified", 32'(n_mod), 32'd0);
        check("pt_pix_3_5", 32'(cap[key(3, 5)]), 32'h03050E);

        // Solid cursor at (100,50).
        cursor_en = 1'b1;
        frame(68, 120, 9999, -1, -1, 0);
        check("solid_modified", 32'(n_mod), 32'd256);
        check("solid_100_50",   32'(cap[key(100, 50)]), 32'hFF0000);
        check("solid_115_65",   32'(cap[key(115, 65)]), 32'hFF0000);
        check("solid_99_50",    32'(cap[key(99, 50)]),  32'h63325B);
        check("solid_116_50",   32'(cap[key(116, 50)]), 32'h74328E);
        check("solid_100_49",   32'(cap[key(100, 49)]), 32'h64315D);
        check("solid_100_66",   32'(cap[key(100, 66)]), 32'h64426E);

        // Invert mode, row 0 = 8001, flat input colour.
        load_bitmap(16'h8001, 16'h0000);
        idle(20);
        const_rgb = 1'b1;
        cursor_mode = 1'b1; cursor_x = 10'd10; cursor_y = 9'd3;
        frame(8, 40, 9999, -1, -1, 0);
        check("inv_modified", 32'(n_mod), 32'd2);
        check("inv_10_3", 32'(cap[key(10, 3)]), 32'hEDCBA9);
        check("inv_25_3", 32'(cap[key(25, 3)]), 32'hEDCBA9);
        check("inv_11_3", 32'(cap[key(11, 3)]), 32'h123456);
        const_rgb = 1'b0;

        // Position change mid-frame only lands on the next frame.
        load_bitmap(16'hFFFF, 16'hFFFF);
        idle(20);
        cursor_mode = 1'b0; cursor_x = 10'd100; cursor_y = 9'd0;
        frame(20, 220, 9999, -1, 5, 200);
        check("coh_cur_modified", 32'(n_mod), 32'd256);
        check("coh_cur_100_10",   32'(cap[key(100, 10)]), 32'hFF0000);
        check("coh_cur_200_10",   32'(cap[key(200, 10)]), 32'hC80A62);
        frame(20, 220, 9999, -1, -1, 0);
        check("coh_next_200_10",  32'(cap[key(200, 10)]), 32'hFF0000);
        check("coh_next_100_10",  32'(cap[key(100, 10)]), 32'h640A36);

        // Bottom-right clipping: only a 5x5 corner shows.
        cursor_x = 10'd795; cursor_y = 9'd475;
        frame(480, 4, 475, -1, -1, 0);
        check("clip_modified", 32'(n_mod), 32'd25);
        check("clip_795_475",  32'(cap[key(795, 475)]), 32'hFF0000);
        check("clip_799_479",  32'(cap[key(799, 479)]), 32'hFF0000);
        check("clip_794_475",  32'(cap[key(794, 475)]), 32'h1ADB29);
        check("clip_0_476",    32'(cap[key(0, 476)]),   32'h00DCDC);

        // Reset during line 200: nothing drawn until the next frame.
        cursor_x = 10'd2; cursor_y = 9'd205;
        frame(225, 20, 9999, 200, -1, 0);
        check("rst_frame_modified", 32'(n_mod), 32'd0);
        frame(225, 20, 9999, -1, -1, 0);
        check("post_rst_modified", 32'(n_mod), 32'd256);
        check("post_rst_2_205",    32'(cap[key(2, 205)]), 32'hFF0000);

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
